// File: rtl/ws2812_rx.sv
// WS2811/WS2812/SK6812 single-wire receiver: classifies DI high pulses as 0/1 and assembles 24-bit GRB pixels.
// Latency: pixel_valid rises 4 clk edges after the DI fall of the 24th bit enters the synchronizer.
// Backpressure: none; pixel_valid/frame_done/error are single-cycle strobes that the consumer must take.
module ws2812_rx #(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 50000000,
  localparam int AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          DI,
  output logic          pixel_valid,
  output logic [AW-1:0] address,
  output logic [7:0]    green_out,
  output logic [7:0]    red_out,
  output logic [7:0]    blue_out,
  output logic          frame_done,
  output logic          overflow,
  output logic          error
);

  // Protocol timing derived from the clock frequency (800 kbit/s line rate, 50 us reset gap)
  localparam int CYCLE_COUNT  = SYSTEM_CLOCK / 800_000;
  localparam int H0           = CYCLE_COUNT / 4;
  localparam int H1           = CYCLE_COUNT / 2;
  localparam int THRESH       = (H0 + H1) / 2;
  localparam int MAX_HIGH     = 2 * CYCLE_COUNT;
  localparam int RESET_DETECT = SYSTEM_CLOCK / 20_000;

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_DETECT + 1);
  localparam int IW = $clog2(NUM_LEDS + 1);

  localparam logic [HW-1:0] THRESH_C   = HW'(THRESH);
  localparam logic [HW-1:0] MAX_HIGH_C = HW'(MAX_HIGH);
  localparam logic [LW-1:0] GAP_LAST_C = LW'(RESET_DETECT - 1);
  localparam logic [IW-1:0] NUM_LEDS_C = IW'(NUM_LEDS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic          di_m;
  logic          di_s;
  logic          di_d;
  logic          rise;
  logic          fall;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   sreg;
  logic [IW-1:0] pix_idx;
  logic          pix_pend;

  // Bring DI into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      di_m <= 1'b0;
      di_s <= 1'b0;
      di_d <= 1'b0;
    end else begin
      di_m <= DI;
      di_s <= di_m;
      di_d <= di_s;
    end
  end

  assign rise = di_s & ~di_d;
  assign fall = ~di_s & di_d;

  // Decoder FSM: pulse-width classification, pixel assembly, gap detection and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
      pix_idx     <= '0;
      pix_pend    <= 1'b0;
      pixel_valid <= 1'b0;
      address     <= '0;
      green_out   <= '0;
      red_out     <= '0;
      blue_out    <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      // A full pixel was shifted in on the previous cycle: present it or flag overflow
      if (pix_pend) begin
        pix_pend <= 1'b0;
        if (pix_idx < NUM_LEDS_C) begin
          pixel_valid <= 1'b1;
          address     <= pix_idx[AW-1:0];
          green_out   <= sreg[23:16];
          red_out     <= sreg[15:8];
          blue_out    <= sreg[7:0];
          pix_idx     <= pix_idx + IW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end

      case (state)
        SYNC: begin
          // Only a full low gap proves we are aligned to a frame boundary
          if (di_s) begin
            low_cnt <= '0;
          end else if (low_cnt == GAP_LAST_C) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end

        IDLE: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= HW'(1);
            overflow <= 1'b0;
            bit_cnt  <= '0;
            pix_idx  <= '0;
          end
        end

        HIGH: begin
          if (fall) begin
            // high_cnt equals the number of high cycles seen, so it is the pulse width
            sreg    <= {sreg[22:0], (high_cnt >= THRESH_C)};
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              pix_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
            low_cnt <= LW'(1);
            state   <= LOW;
          end else if (high_cnt == MAX_HIGH_C) begin
            // Pulse longer than any legal bit: drop alignment and wait for a fresh gap
            error   <= 1'b1;
            low_cnt <= '0;
            state   <= SYNC;
          end else begin
            high_cnt <= high_cnt + HW'(1);
          end
        end

        LOW: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= HW'(1);
          end else if (low_cnt == GAP_LAST_C) begin
            // Reset gap: frame ends, a dangling partial pixel is a protocol error
            frame_done <= 1'b1;
            pix_idx    <= '0;
            low_cnt    <= '0;
            state      <= IDLE;
            if (bit_cnt != 5'd0) begin
              error   <= 1'b1;
              bit_cnt <= '0;
            end
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Testbench for ws2812_rx: drives randomized WS2812 waveforms and checks against a bit-level frame model.
// Latency: outputs sampled on the falling clock edge; results compared at the end of each frame gap.
// Backpressure: none; every DUT strobe is logged by a free-running monitor.
module tb_ws2812_rx;

  localparam int NUM_LEDS = 4;
  localparam int THRESH   = 23;
  localparam int RD       = 2500;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       DI = 1'b0;
  logic       pixel_valid;
  logic [1:0] address;
  logic [7:0] green_out;
  logic [7:0] red_out;
  logic [7:0] blue_out;
  logic       frame_done;
  logic       overflow;
  logic       error;

  always #10 clk = ~clk;

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(50000000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .DI          (DI),
    .pixel_valid (pixel_valid),
    .address     (address),
    .green_out   (green_out),
    .red_out     (red_out),
    .blue_out    (blue_out),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .error       (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: log every strobe seen on the falling edge
  logic [25:0] got_pix[$];
  int fd_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (pixel_valid) got_pix.push_back({address, green_out, red_out, blue_out});
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
    if (frame_done && error) both_cnt++;
  end

  // Reference model: bits grouped into 24-bit words, numbered within a frame
  logic [25:0] exp_pix[$];
  logic [23:0] m_acc = '0;
  int  m_bits = 0;
  int  m_idx = 0;
  bit  m_ov = 1'b0;
  bit  m_inframe = 1'b0;
  bit  m_ignore = 1'b0;
  int  pix_base = 0;
  int  fd_base = 0;
  int  err_base = 0;
  int  both_base = 0;

  task automatic model_bit(input bit b);
    if (m_ignore) return;
    if (!m_inframe) begin
      m_inframe = 1'b1;
      m_bits    = 0;
      m_idx     = 0;
      m_ov      = 1'b0;
    end
    m_acc = {m_acc[22:0], b};
    m_bits++;
    if (m_bits % 24 == 0) begin
      if (m_idx < NUM_LEDS) exp_pix.push_back({2'(m_idx), m_acc});
      else m_ov = 1'b1;
      m_idx++;
    end
  endtask

  task automatic hold(input logic v, input int n);
    DI = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit_w(input int w, input int low, input bit b);
    hold(1'b1, w);
    hold(1'b0, low);
    model_bit(b);
  endtask

  task automatic send_bit(input bit b);
    int w;
    w = b ? int'($urandom_range(40, THRESH)) : int'($urandom_range(THRESH - 1, 5));
    send_bit_w(w, int'($urandom_range(40, 5)), b);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  // Close a frame with a reset gap and compare everything logged against the model
  task automatic end_frame(input int extra_err, input string tag);
    int exp_fd;
    int exp_part;
    int npix;
    exp_fd   = (m_inframe && m_bits > 0) ? 1 : 0;
    exp_part = (m_inframe && (m_bits % 24) != 0) ? 1 : 0;
    hold(1'b0, RD);
    hold(1'b0, 10);
    npix = got_pix.size() - pix_base;
    check({tag, ":frame_done"}, fd_cnt - fd_base, exp_fd);
    check({tag, ":error"}, err_cnt - err_base, extra_err + exp_part);
    check({tag, ":done_err_same"}, both_cnt - both_base, exp_part);
    check({tag, ":npix"}, npix, exp_pix.size());
    for (int i = 0; i < exp_pix.size(); i++)
      if (i < npix) check({tag, ":pix"}, got_pix[pix_base + i], exp_pix[i]);
    check({tag, ":overflow"}, overflow, m_ov);
    pix_base  = got_pix.size();
    fd_base   = fd_cnt;
    err_base  = err_cnt;
    both_base = both_cnt;
    exp_pix.delete();
    m_inframe = 1'b0;
  endtask

  initial begin
    logic [23:0] t1_pix;

    reset_n = 1'b0;
    DI = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {green_out, red_out, blue_out}, 24'h0);
    check("rst_flags", {pixel_valid, frame_done, overflow, error, address}, 6'h0);
    reset_n = 1'b1;

    // Nominal H0/H1 pulses at 62-clk bit period
    hold(1'b0, RD);
    t1_pix = 24'h123456;
    for (int i = 23; i >= 0; i--)
      send_bit_w(t1_pix[i] ? 31 : 15, t1_pix[i] ? 31 : 47, t1_pix[i]);
    end_frame(0, "t1");

    // Exactly NUM_LEDS pixels, then one too many
    send_pixel(24'h010203);
    send_pixel(24'h040506);
    send_pixel(24'h070809);
    send_pixel(24'h0A0B0C);
    end_frame(0, "t2a");
    for (int i = 0; i < 5; i++) send_pixel(24'($urandom));
    end_frame(0, "t2b");

    // Partial pixel: error with frame_done, overflow cleared by new frame
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    check("t3:overflow_cleared", overflow, m_ov);
    end_frame(0, "t3");
    send_pixel(24'($urandom));
    end_frame(0, "t3b");

    // Stuck-high line: one error, traffic ignored until a full gap
    m_ignore = 1'b1;
    hold(1'b1, 200);
    hold(1'b0, 20);
    send_pixel(24'($urandom));
    m_ignore = 1'b0;
    end_frame(1, "t4");
    send_pixel(24'($urandom));
    end_frame(0, "t4b");

    // Threshold edges, maximum legal high, and longest low that is not a gap
    send_bit_w(22, 40, 1'b0);
    for (int i = 0; i < 22; i++) send_bit(1'b0);
    send_bit_w(10, RD - 1, 1'b0);
    send_bit_w(23, 39, 1'b1);
    for (int i = 0; i < 22; i++) send_bit(1'b0);
    send_bit_w(124, 20, 1'b1);
    end_frame(0, "t5");

    // Reset in the middle of a frame
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    reset_n = 1'b0;
    #1;
    check("t6:rst_data", {green_out, red_out, blue_out}, 24'h0);
    check("t6:rst_flags", {pixel_valid, frame_done, overflow, error, address}, 6'h0);
    m_inframe = 1'b0;
    m_bits = 0;
    m_ov = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ignore = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    m_ignore = 1'b0;
    end_frame(0, "t6a");
    send_pixel(24'($urandom));
    end_frame(0, "t6b");

    // Random frames of random length
    for (int f = 0; f < 2; f++) begin
      int n;
      n = int'($urandom_range(5, 1));
      for (int i = 0; i < n; i++) send_pixel(24'($urandom));
      end_frame(0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
